mesh_sim_ctrl: RTL and testbench

Simulation run controller for the multi-node CPU mesh. It releases the per-node CPU resets on a start pulse and counts run cycles. Completion is detected when every node has halted (sticky) or a cycle timeout expires. It then walks every node's data RAM through a backdoor read port and streams each word out on a valid/ready dump interface. This replaces the fixed-size, open-ended run/dump loop with a parametrised, synthesisable sequencer that has a timeout.

---
 rtl/mesh_sim_ctrl_if.sv | 42 ++++
 rtl/mesh_sim_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mesh_sim_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesh_sim_ctrl_if.sv
// ---------------------------------------------------------------------------
// mesh_sim_ctrl_if
// Bundles the two bus-like ports of the mesh run controller:
//   - backdoor RAM read port: mem_req/mem_node/mem_addr out, mem_rdata/mem_rvalid in
//   - dump stream (valid/ready): dump_valid/dump_node/dump_addr/dump_data out,
//     dump_ready in
// The master modport is the controller's view and the slave modport is the
// RAM/consumer side.
// ---------------------------------------------------------------------------
interface mesh_sim_ctrl_if #(
    parameter int NODES  = 16,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    localparam int NODE_W = $clog2(NODES);

    logic              mem_req;
    logic [NODE_W-1:0] mem_node;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic              dump_valid;
    logic              dump_ready;
    logic [NODE_W-1:0] dump_node;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;

    modport master (
        output mem_req, mem_node, mem_addr,
        input  mem_rdata, mem_rvalid,
        output dump_valid, dump_node, dump_addr, dump_data,
        input  dump_ready
    );

    modport slave (
        input  mem_req, mem_node, mem_addr,
        output mem_rdata, mem_rvalid,
        input  dump_valid, dump_node, dump_addr, dump_data,
        output dump_ready
    );
endinterface

// File: rtl/mesh_sim_ctrl.sv
// ---------------------------------------------------------------------------
// mesh_sim_ctrl
// Run controller for the multi-node CPU mesh. A start pulse releases all CPU
// resets and starts a saturating run-cycle counter. The run ends when every
// node has raised halt at least once (sticky) or when the cycle timeout
// expires. Every node's RAM is then read word by word through the backdoor
// port and streamed out on the dump interface, node-major and address-
// ascending. DONE is terminal until reset.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        run start pulse (only honoured in IDLE)
//   halt         per-node halt flags (only sampled in RUN)
//   cpu_rst_n    per-node CPU reset, all ones only while running
//   bus          backdoor read port + dump stream (mesh_sim_ctrl_if.master)
//   cycle_count  run cycles elapsed, saturating, frozen after the run
//   busy         high while running or dumping
//   timed_out    run was ended by the timeout (sticky)
//   done         dump finished (sticky)
// ---------------------------------------------------------------------------
module mesh_sim_ctrl #(
    parameter int NODES   = 16,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NODES-1:0]   halt,
    output logic [NODES-1:0]   cpu_rst_n,
    mesh_sim_ctrl_if.master    bus,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               busy,
    output logic               timed_out,
    output logic               done
);
    localparam int NODE_W = $clog2(NODES);

    // Count value seen in the last permitted run cycle; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [NODE_W-1:0] LAST_NODE   = NODE_W'(NODES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DUMP_REQ,
        DUMP_WAIT,
        DUMP_OUT,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [NODES-1:0]  halted_q;
    logic [NODE_W-1:0] node_ptr;
    logic [ADDR_W-1:0] addr_ptr;
    logic [DATA_W-1:0] dump_data_q;

    logic all_halted;
    logic timeout_hit;
    logic last_word;
    logic exit_by_timeout;

    // Include this cycle's halt so a node halting on the final cycle counts.
    assign all_halted  = &(halted_q | halt);
    assign timeout_hit = (TIMEOUT != 0) && (cycle_count == TIMEOUT_LAST);
    assign last_word   = (node_ptr == LAST_NODE) && (addr_ptr == '1);

    // Read and dump addressing both come straight from the walk pointers.
    assign bus.mem_node  = node_ptr;
    assign bus.mem_addr  = addr_ptr;
    assign bus.dump_node = node_ptr;
    assign bus.dump_addr = addr_ptr;
    assign bus.dump_data = dump_data_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs. An all-halted run wins over a
    // coincident timeout, so the timeout branch is checked second.
    always_comb begin
        state_d         = state_q;
        exit_by_timeout = 1'b0;
        cpu_rst_n       = '0;
        busy            = 1'b0;
        done            = 1'b0;
        bus.mem_req     = 1'b0;
        bus.dump_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cpu_rst_n = '1;
                busy      = 1'b1;
                if (all_halted) begin
                    state_d = DUMP_REQ;
                end else if (timeout_hit) begin
                    state_d         = DUMP_REQ;
                    exit_by_timeout = 1'b1;
                end
            end
            DUMP_REQ: begin
                busy        = 1'b1;
                bus.mem_req = 1'b1;
                state_d     = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                busy = 1'b1;
                if (bus.mem_rvalid) begin
                    state_d = DUMP_OUT;
                end
            end
            DUMP_OUT: begin
                busy           = 1'b1;
                bus.dump_valid = 1'b1;
                if (bus.dump_ready) begin
                    state_d = last_word ? DONE : DUMP_REQ;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: halt latch, run counter, timeout flag, walk pointers and the
    // captured dump word. The pointers advance only on a dump handshake, so
    // the dump fields stay stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q    <= '0;
            cycle_count <= '0;
            timed_out   <= 1'b0;
            node_ptr    <= '0;
            addr_ptr    <= '0;
            dump_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        halted_q    <= '0;
                        cycle_count <= '0;
                        timed_out   <= 1'b0;
                        node_ptr    <= '0;
                        addr_ptr    <= '0;
                    end
                end
                RUN: begin
                    halted_q <= halted_q | halt;
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    if (state_d != RUN) begin
                        node_ptr  <= '0;
                        addr_ptr  <= '0;
                        timed_out <= exit_by_timeout;
                    end
                end
                DUMP_WAIT: begin
                    if (bus.mem_rvalid) begin
                        dump_data_q <= bus.mem_rdata;
                    end
                end
                DUMP_OUT: begin
                    if (bus.dump_ready) begin
                        if (addr_ptr == '1) begin
                            addr_ptr <= '0;
                            node_ptr <= node_ptr + 1'b1;
                        end else begin
                            addr_ptr <= addr_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mesh_sim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mesh_sim_ctrl
// Bench for mesh_sim_ctrl with NODES=2, ADDR_W=2, TIMEOUT=20. Each scenario
// derives the run length from the halt schedule (latest first-halt versus the
// timeout), builds the expected dump word list, and a per-cycle monitor checks
// the DUT against that. A RAM responder returns node*16+addr with fixed or
// random latency; dump_ready is either always high or random at 30%.
// ---------------------------------------------------------------------------
module tb_mesh_sim_ctrl;
    localparam int NODES   = 2;
    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 20;
    localparam int NODE_W  = $clog2(NODES);
    localparam int WORDS   = NODES * (1 << ADDR_W);

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [NODES-1:0]  halt;
    logic [NODES-1:0]  cpu_rst_n;
    logic [CNT_W-1:0]  cycle_count;
    logic              busy;
    logic              timed_out;
    logic              done;

    mesh_sim_ctrl_if #(.NODES(NODES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mesh_sim_ctrl #(
        .NODES(NODES), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .halt(halt),
        .cpu_rst_n(cpu_rst_n),
        .bus(bus),
        .cycle_count(cycle_count),
        .busy(busy),
        .timed_out(timed_out),
        .done(done)
    );

    typedef struct {
        int node;
        int addr;
        int data;
    } word_t;

    int     checks   = 0;
    int     failures = 0;
    word_t  exp_q[$];
    bit     mon_en   = 0;
    bit     bp_mode  = 0;
    int     run_idx  = 0;
    int     exp_end  = 0;
    bit     exp_to   = 0;
    bit     dump_finished = 0;
    bit     prev_stall = 0;
    int     hs_count  = 0;
    int     req_count = 0;
    logic [NODE_W-1:0] prev_node;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check_output(input string name, input logic [63:0] actual,
                                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endfunction

    function automatic void check_reset_outputs(input string tag);
        check_output({tag, "_cpu_rst_n"},   64'(cpu_rst_n), 64'(0));
        check_output({tag, "_busy"},        64'(busy), 64'(0));
        check_output({tag, "_done"},        64'(done), 64'(0));
        check_output({tag, "_timed_out"},   64'(timed_out), 64'(0));
        check_output({tag, "_cycle_count"}, 64'(cycle_count), 64'(0));
        check_output({tag, "_mem_req"},     64'(bus.mem_req), 64'(0));
        check_output({tag, "_mem_node"},    64'(bus.mem_node), 64'(0));
        check_output({tag, "_mem_addr"},    64'(bus.mem_addr), 64'(0));
        check_output({tag, "_dump_valid"},  64'(bus.dump_valid), 64'(0));
        check_output({tag, "_dump_node"},   64'(bus.dump_node), 64'(0));
        check_output({tag, "_dump_addr"},   64'(bus.dump_addr), 64'(0));
        check_output({tag, "_dump_data"},   64'(bus.dump_data), 64'(0));
    endfunction

    // RAM model: answers each request with node*16+addr after 1 cycle, or
    // 1-4 cycles under backpressure. Data bus carries junk when not valid.
    initial begin
        int lat;
        int n;
        int a;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_req) begin
                n   = int'(bus.mem_node);
                a   = int'(bus.mem_addr);
                lat = bp_mode ? int'($urandom_range(1, 4)) : 1;
                repeat (lat) @(posedge clk);
                #1;
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = DATA_W'(n * 16 + a);
                @(posedge clk);
                #1;
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // Consumer ready: always high, or 30% duty under backpressure.
    initial begin
        bus.dump_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.dump_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Per-cycle monitor: run phase, dump phase (stability + scoreboard), done phase.
    always @(negedge clk) begin
        word_t w;
        if (mon_en) begin
            if (bus.mem_req) req_count++;
            if (run_idx <= exp_end) begin
                check_output("run_busy",        64'(busy), 64'(1));
                check_output("run_cpu_rst_n",   64'(cpu_rst_n), 64'({NODES{1'b1}}));
                check_output("run_cycle_count", 64'(cycle_count), 64'(run_idx));
                check_output("run_timed_out",   64'(timed_out), 64'(0));
                check_output("run_mem_req",     64'(bus.mem_req), 64'(0));
                check_output("run_dump_valid",  64'(bus.dump_valid), 64'(0));
                check_output("run_done",        64'(done), 64'(0));
            end else if (!dump_finished) begin
                check_output("dump_busy",        64'(busy), 64'(1));
                check_output("dump_cpu_rst_n",   64'(cpu_rst_n), 64'(0));
                check_output("dump_cycle_count", 64'(cycle_count), 64'(exp_end + 1));
                check_output("dump_timed_out",   64'(timed_out), 64'(exp_to));
                check_output("dump_done",        64'(done), 64'(0));
                if (prev_stall) begin
                    check_output("stall_valid", 64'(bus.dump_valid), 64'(1));
                    check_output("stall_node",  64'(bus.dump_node), 64'(prev_node));
                    check_output("stall_addr",  64'(bus.dump_addr), 64'(prev_addr));
                    check_output("stall_data",  64'(bus.dump_data), 64'(prev_data));
                end
                if (bus.dump_valid && bus.dump_ready) begin
                    if (exp_q.size() == 0) begin
                        check_output("extra_word", 64'(hs_count + 1), 64'(WORDS));
                    end else begin
                        w = exp_q.pop_front();
                        check_output("word_node", 64'(bus.dump_node), 64'(w.node));
                        check_output("word_addr", 64'(bus.dump_addr), 64'(w.addr));
                        check_output("word_data", 64'(bus.dump_data), 64'(w.data));
                        hs_count++;
                        if (exp_q.size() == 0) dump_finished = 1;
                    end
                end
                prev_stall = bus.dump_valid && !bus.dump_ready;
                prev_node  = bus.dump_node;
                prev_addr  = bus.dump_addr;
                prev_data  = bus.dump_data;
            end else begin
                check_output("done_done",        64'(done), 64'(1));
                check_output("done_busy",        64'(busy), 64'(0));
                check_output("done_dump_valid",  64'(bus.dump_valid), 64'(0));
                check_output("done_mem_req",     64'(bus.mem_req), 64'(0));
                check_output("done_cpu_rst_n",   64'(cpu_rst_n), 64'(0));
                check_output("done_cycle_count", 64'(cycle_count), 64'(exp_end + 1));
                check_output("done_timed_out",   64'(timed_out), 64'(exp_to));
            end
            run_idx++;
        end
    end

    // Reset with start toggling underneath; outputs must read zero throughout.
    task automatic do_reset(input string tag);
        mon_en = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        halt  = '0;
        #1;
        check_reset_outputs({tag, "_in"});
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check_reset_outputs({tag, "_hold"});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs({tag, "_idle"});
    endtask

    // Start a run with the given halt schedule. halt[0] is held from h0 on;
    // halt[1] is held from h1 on, or pulsed only at h1.
    task automatic apply_stimulus(input int h0, input int h1, input bit h1_pulse, input bit bp);
        int end_allh;
        word_t w;
        end_allh = (h0 > h1) ? h0 : h1;
        exp_end  = (end_allh < TIMEOUT - 1) ? end_allh : TIMEOUT - 1;
        exp_to   = (end_allh > TIMEOUT - 1);
        exp_q.delete();
        for (int n = 0; n < NODES; n++) begin
            for (int a = 0; a < (1 << ADDR_W); a++) begin
                w.node = n;
                w.addr = a;
                w.data = n * 16 + a;
                exp_q.push_back(w);
            end
        end
        dump_finished = 0;
        prev_stall    = 0;
        hs_count      = 0;
        req_count     = 0;
        bp_mode       = bp;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        run_idx = 0;
        mon_en  = 1;
        for (int r = 0; r <= exp_end; r++) begin
            halt[0] = (r >= h0);
            halt[1] = h1_pulse ? (r == h1) : (r >= h1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_scenario(input string tag, input int lit_cnt, input bit lit_to);
        int budget;
        budget = 0;
        while (!dump_finished && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        if (!dump_finished) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_dump_timeout: got %0d words, expected %0d", tag, hs_count, WORDS);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        check_output({tag, "_cycle_count"}, 64'(cycle_count), 64'(lit_cnt));
        check_output({tag, "_timed_out"},   64'(timed_out), 64'(lit_to));
        check_output({tag, "_done"},        64'(done), 64'(1));
        check_output({tag, "_words"},       64'(hs_count), 64'(8));
        check_output({tag, "_mem_reqs"},    64'(req_count), 64'(8));
        mon_en  = 0;
        bp_mode = 0;
    endtask

    initial begin
        int budget;
        rst_n = 1'b0;
        start = 1'b0;
        halt  = '0;
        #1;
        check_reset_outputs("por");

        do_reset("rst0");
        $display("[TB] normal run");
        apply_stimulus(3, 6, 1'b1, 1'b0);
        finish_scenario("normal", 7, 1'b0);

        do_reset("rst1");
        $display("[TB] timeout run");
        apply_stimulus(3, 1000, 1'b0, 1'b0);
        finish_scenario("timeout", 20, 1'b1);

        do_reset("rst2");
        $display("[TB] halt/timeout tie");
        apply_stimulus(0, 19, 1'b0, 1'b0);
        finish_scenario("tie", 20, 1'b0);

        do_reset("rst3");
        $display("[TB] backpressure run");
        apply_stimulus(2, 4, 1'b0, 1'b1);
        finish_scenario("bp", 5, 1'b0);

        do_reset("rst4");
        $display("[TB] reset during fifth word");
        apply_stimulus(3, 6, 1'b1, 1'b0);
        budget = 0;
        do begin
            @(posedge clk);
            #2;
            budget++;
        end while (!(hs_count == 4 && bus.dump_valid) && budget < 500);
        check_output("abort_reached_word5", 64'(hs_count == 4 && bus.dump_valid), 64'(1));
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(3, 6, 1'b1, 1'b0);
        finish_scenario("restart", 7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at t=%0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
